// File: rtl/button_debouncer.sv
// Push-button conditioner: flop-chain synchroniser followed by a counter-qualified
// 4-state debounce FSM driving registered active-low b_clean and b_busy.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic b_raw,
  output logic b_clean,
  output logic b_busy
);

  typedef enum logic [1:0] {
    RELEASED = 2'b00,
    CHK_LOW  = 2'b01,
    PRESSED  = 2'b10,
    CHK_HIGH = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s;
  state_t                 state_r, state_nx;
  logic [CNT_WIDTH-1:0]   cnt_r, cnt_nx;
  logic                   clean_nx, busy_nx;

  // Synchroniser chain; idles high so reset looks like a released button
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], b_raw};
    end
  end

  assign s = sync_r[SYNC_STAGES-1];

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= RELEASED;
      cnt_r   <= '0;
      b_clean <= 1'b1;
      b_busy  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      b_clean <= clean_nx;
      b_busy  <= busy_nx;
    end
  end

  // Next-state and counter logic; the counter is cleared on every state exit
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    case (state_r)
      RELEASED: begin
        if (!s) begin
          state_nx = CHK_LOW;
          cnt_nx   = '0;
        end else begin
          state_nx = RELEASED;
        end
      end
      CHK_LOW: begin
        if (s) begin
          state_nx = RELEASED;
          cnt_nx   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_r + CNT_WIDTH'(1);
        end
      end
      PRESSED: begin
        if (s) begin
          state_nx = CHK_HIGH;
          cnt_nx   = '0;
        end else begin
          state_nx = PRESSED;
        end
      end
      CHK_HIGH: begin
        if (!s) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nx = RELEASED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_r + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nx = RELEASED;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are decoded from the current state and registered one edge later
  always_comb begin
    clean_nx = 1'b1;
    busy_nx  = 1'b0;
    case (state_r)
      RELEASED: begin
        clean_nx = 1'b1;
        busy_nx  = 1'b0;
      end
      CHK_LOW: begin
        clean_nx = 1'b1;
        busy_nx  = 1'b1;
      end
      PRESSED: begin
        clean_nx = 1'b0;
        busy_nx  = 1'b0;
      end
      CHK_HIGH: begin
        clean_nx = 1'b0;
        busy_nx  = 1'b1;
      end
      default: begin
        clean_nx = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench: directed scenarios plus randomized bouncing, compared every
// cycle against a sliding-window model of the debounce rule.
module tb_button_debouncer;

  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic b_raw = 1'b1;
  logic b_clean, b_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model: raw sample history, synchronised-sample window, accepted level
  logic rh [0:SYNC];
  logic sh [0:DC];
  logic m_d, m_bst, m_oc, m_ob;

  button_debouncer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH      (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .b_raw  (b_raw),
    .b_clean(b_clean),
    .b_busy (b_busy)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // A change is accepted once the last DC+1 synchronised samples all oppose it
  task automatic model_edge(input logic raw_v, input logic rst_v);
    logic all_opp;
    if (!rst_v) begin
      for (int i = 0; i <= SYNC; i++) rh[i] = 1'b1;
      for (int i = 0; i <= DC; i++) sh[i] = 1'b1;
      m_d = 1'b1; m_bst = 1'b0; m_oc = 1'b1; m_ob = 1'b0;
    end else begin
      m_oc = m_d;
      m_ob = m_bst;
      for (int i = SYNC; i > 0; i--) rh[i] = rh[i-1];
      rh[0] = raw_v;
      for (int i = DC; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = rh[SYNC];
      all_opp = 1'b1;
      for (int i = 0; i <= DC; i++) if (sh[i] == m_d) all_opp = 1'b0;
      if (all_opp) m_d = ~m_d;
      m_bst = (sh[0] != m_d);
    end
  endtask

  task automatic tick(input logic raw_v, input logic rst_v);
    b_raw = raw_v;
    rst   = rst_v;
    @(posedge clk);
    model_edge(raw_v, rst_v);
    #1;
    check_bit("model_clean", b_clean, m_oc);
    check_bit("model_busy", b_busy, m_ob);
  endtask

  initial begin
    int busy_seen, falls, rises;
    logic prev_c, prev_b, lvl;

    // 1: reset with the button held low
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0);
      check_bit("rst_clean", b_clean, 1'b1);
      check_bit("rst_busy", b_busy, 1'b0);
    end
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);

    // 2: clean press latency
    for (int e = 0; e <= 7; e++) begin
      tick(1'b0, 1'b1);
      if (e == 2) check_bit("press_busy_e2", b_busy, 1'b0);
      if (e == 3) check_bit("press_busy_e3", b_busy, 1'b1);
      if (e == 6) check_bit("press_clean_e6", b_clean, 1'b1);
      if (e == 7) begin
        check_bit("press_clean_e7", b_clean, 1'b0);
        check_bit("press_busy_e7", b_busy, 1'b0);
      end
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);

    // 4: toggling while pressed, then settle high
    for (int i = 0; i < 10; i++) begin
      tick((i % 2) == 0, 1'b1);
      check_bit("toggle_clean", b_clean, 1'b0);
    end
    for (int e = 0; e <= 7; e++) begin
      tick(1'b1, 1'b1);
      if (e == 6) check_bit("release_clean_e6", b_clean, 1'b0);
      if (e == 7) check_bit("release_clean_e7", b_clean, 1'b1);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);

    // 3: short low pulse is a bounce
    busy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      if (b_busy) busy_seen = 1;
      check_bit("bounce_clean", b_clean, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1);
      if (b_busy) busy_seen = 1;
      check_bit("bounce_clean", b_clean, 1'b1);
    end
    check_bit("bounce_busy_pulse", busy_seen[0], 1'b1);
    check_bit("bounce_busy_idle", b_busy, 1'b0);

    // 5: reset in CHK_LOW with cnt=2 aborts qualification
    for (int e = 0; e <= 4; e++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check_bit("abort_clean", b_clean, 1'b1);
    check_bit("abort_busy", b_busy, 1'b0);
    for (int e = 6; e <= 13; e++) begin
      tick(1'b0, 1'b1);
      if (e == 12) check_bit("requal_clean_e12", b_clean, 1'b1);
      if (e == 13) check_bit("requal_clean_e13", b_clean, 1'b0);
    end
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);

    // 6: long hold gives one transition and one busy burst
    falls = 0; rises = 0;
    prev_c = b_clean; prev_b = b_busy;
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0, 1'b1);
      if (prev_c && !b_clean) falls++;
      if (!prev_b && b_busy) rises++;
      prev_c = b_clean; prev_b = b_busy;
    end
    check_bit("hold_one_fall", falls == 1, 1'b1);
    check_bit("hold_one_busy", rises == 1, 1'b1);

    // Randomized bouncing runs with occasional resets
    lvl = 1'b1;
    for (int r = 0; r < 150; r++) begin
      int len;
      lvl = $urandom_range(0, 3) == 0 ? lvl : ~lvl;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) tick(lvl, ($urandom_range(0, 60) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
